// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, paired imem reads and a BUF_DEPTH-entry fetch buffer
// with branch-redirect flush. Define FETCH_PERF_CNT_EN to add the redirect_cnt/stall_cnt outputs.
module fetch_unit #(
  parameter int BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  input  logic        halt,
  output logic        imem_rd,
  output logic [6:0]  imem_addr,
  input  logic [0:63] imem_data,
  output logic        out_valid,
  input  logic        dec_ready,
  output logic [7:0]  out_pc,
  output logic [31:0] out_instr0,
  output logic [31:0] out_instr1,
  output logic        out_v0,
  output logic        out_v1
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {FETCH, FULL, HALTED} state_e;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic        v0;
    logic        v1;
  } entry_t;

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             pend_q, pend_d;
  logic [7:0]       pend_pc_q, pend_pc_d;
  logic             pend_v0_q, pend_v0_d;
  entry_t           buf_q [BUF_DEPTH];
  entry_t           buf_d [BUF_DEPTH];
  entry_t           head;

  logic             empty, space, issue, push, pop;
  logic [CNT_W:0]   occ_now, occ_next;

  always_comb begin
    empty   = (count_q == '0);
    // A same-cycle pop is deliberately not credited, so an issued read always has a free slot.
    occ_now = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
    space   = (occ_now < DEPTH_C);
    issue   = (state_q == FETCH) && space && !redirect_valid;
    push    = pend_q && !redirect_valid;
    pop     = !empty && !redirect_valid && dec_ready;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    pc_d      = pc_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pend_d    = issue;
    pend_pc_d = pend_pc_q;
    pend_v0_d = pend_v0_q;
    buf_d     = buf_q;
    state_d   = state_q;

    if (issue) begin
      pc_d      = {pc_q[7:1], 1'b0} + 8'd2;
      pend_pc_d = {pc_q[7:1], 1'b0};
      pend_v0_d = ~pc_q[0];
    end

    if (push) begin
      buf_d[wr_ptr_q] = '{pc: pend_pc_q, instr0: imem_data[0:31], instr1: imem_data[32:63],
                          v0: pend_v0_q, v1: 1'b1};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pend_d   = 1'b0;
    end

    occ_next = {1'b0, count_d} + {{CNT_W{1'b0}}, pend_d};
    if (redirect_valid) begin
      state_d = FETCH;
    end else if (state_q != HALTED) begin
      if (halt)                       state_d = HALTED;
      else if (occ_next >= DEPTH_C)   state_d = FULL;
      else                            state_d = FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      pend_v0_q <= 1'b0;
      // NOTE: the buffer array is reset because the head drives out_* directly and must read 0 in reset.
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      pend_v0_q <= pend_v0_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    head       = buf_q[rd_ptr_q];
    // The read strobe is held low while reset is asserted even though the state reads FETCH.
    imem_rd    = issue && reset;
    imem_addr  = pc_q[7:1];
    out_valid  = !empty && !redirect_valid;
    out_pc     = head.pc;
    out_instr0 = head.instr0;
    out_instr1 = head.instr1;
    out_v0     = head.v0;
    out_v1     = head.v1;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (redirect_valid && (redirect_cnt_q != 16'hFFFF)) redirect_cnt_d = redirect_cnt_q + 16'd1;
    if (out_valid && !dec_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios plus randomized traffic checked
// by a transaction-level scoreboard (expected pc stream, memory contents, occupancy bound).
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic        imem_rd;
  logic [6:0]  imem_addr;
  logic [0:63] imem_data;
  logic        out_valid;
  logic        dec_ready;
  logic [7:0]  out_pc;
  logic [31:0] out_instr0, out_instr1;
  logic        out_v0, out_v1;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redirect_cnt, stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [0:63] mem [128];

  fetch_unit #(.BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .dec_ready(dec_ready), .out_pc(out_pc),
    .out_instr0(out_instr0), .out_instr1(out_instr1), .out_v0(out_v0), .out_v1(out_v1)
`ifdef FETCH_PERF_CNT_EN
    , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: pair returned one cycle after the read strobe.
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  // Scoreboard state: next expected pair, next expected read address, reads not yet consumed.
  int         outstanding;
  logic [7:0] exp_pc;
  logic       exp_v0;
  logic [6:0] fetch_addr;

  always @(negedge clk) begin
    logic [0:63] w;
    if (!reset) begin
      outstanding = 0;
      exp_pc      = 8'h00;
      exp_v0      = 1'b1;
      fetch_addr  = 7'h00;
    end else begin
      if (imem_rd) begin
        vectors++;
        if (imem_addr !== fetch_addr || outstanding >= DEPTH) begin
          miscompares++;
          $display("FAIL sb_issue: addr=%h outstanding=%0d, expected addr=%h with outstanding<%0d",
                   imem_addr, outstanding, fetch_addr, DEPTH);
        end
        fetch_addr  = fetch_addr + 7'd1;
        outstanding = outstanding + 1;
      end
      if (out_valid && dec_ready) begin
        w = mem[exp_pc[7:1]];
        vectors++;
        if ({out_pc, out_instr0, out_instr1, out_v0, out_v1} !==
            {exp_pc, w[0:31], w[32:63], exp_v0, 1'b1}) begin
          miscompares++;
          $display("FAIL sb_pop: pc=%h i0=%h i1=%h v0=%b v1=%b, expected pc=%h i0=%h i1=%h v0=%b v1=1",
                   out_pc, out_instr0, out_instr1, out_v0, out_v1, exp_pc, w[0:31], w[32:63], exp_v0);
        end
        exp_pc      = exp_pc + 8'd2;
        exp_v0      = 1'b1;
        outstanding = outstanding - 1;
      end
      if (redirect_valid) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL sb_redirect_out_valid: out_valid=%b, expected 0", out_valid);
        end
        outstanding = 0;
        exp_pc      = {redirect_pc[7:1], 1'b0};
        exp_v0      = ~redirect_pc[0];
        fetch_addr  = redirect_pc[7:1];
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_edge();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; halt = 1'b0; dec_ready = 1'b1;
    #1;
    vectors++;
    if ({imem_rd, imem_addr, out_valid, out_pc, out_instr0, out_instr1, out_v0, out_v1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rd=%b addr=%h valid=%b pc=%h i0=%h i1=%h v0=%b v1=%b, expected all 0",
               imem_rd, imem_addr, out_valid, out_pc, out_instr0, out_instr1, out_v0, out_v1);
    end
    repeat (3) drive_edge();
    reset = 1'b1;
    sample();
    vectors++;
    if (imem_rd !== 1'b1 || imem_addr !== 7'h00 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL cycle0: rd=%b addr=%h valid=%b, expected 1/00/0", imem_rd, imem_addr, out_valid);
    end
    drive_edge();
    sample();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL cycle1_valid: out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [0:63] w;
    for (int i = 0; i < 4; i++) begin
      drive_edge();
      sample();
      w = mem[i];
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 8'(2 * i) || out_v0 !== 1'b1 || out_v1 !== 1'b1 ||
          out_instr0 !== w[0:31] || out_instr1 !== w[32:63]) begin
        miscompares++;
        $display("FAIL stream_%0d: valid=%b pc=%h v0=%b v1=%b i0=%h i1=%h, expected 1 pc=%h 1 1 i0=%h i1=%h",
                 i, out_valid, out_pc, out_v0, out_v1, out_instr0, out_instr1, 8'(2 * i), w[0:31], w[32:63]);
      end
    end
  endtask

  task automatic test_backpressure();
    int reads;
    drive_edge();
    reset = 1'b0;
    drive_edge();
    reset = 1'b1; dec_ready = 1'b0;
    reads = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) drive_edge();
      sample();
      if (imem_rd) reads++;
    end
    vectors++;
    if (reads !== DEPTH || imem_rd !== 1'b0 || out_valid !== 1'b1 || out_pc !== 8'h00) begin
      miscompares++;
      $display("FAIL bp_hold: reads=%0d rd=%b valid=%b pc=%h, expected %0d/0/1/00",
               reads, imem_rd, out_valid, out_pc, DEPTH);
    end
    for (int k = 0; k < 5; k++) begin
      drive_edge();
      dec_ready = 1'b1;
      sample();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 8'(2 * k)) begin
        miscompares++;
        $display("FAIL bp_release_%0d: valid=%b pc=%h, expected 1 pc=%h", k, out_valid, out_pc, 8'(2 * k));
      end
    end
  endtask

  // Redirect while a read is in flight; checks the N+1 read and the N+3 head.
  task automatic test_redirect(input logic [7:0] target, input string name);
    logic [7:0] first_pc;
    logic [7:0] second_pc;
    first_pc  = {target[7:1], 1'b0};
    second_pc = first_pc + 8'd2;
    dec_ready = 1'b1;
    repeat (3) begin
      drive_edge();
      sample();
    end
    vectors++;
    if (imem_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_pending: imem_rd=%b, expected 1", name, imem_rd);
    end
    drive_edge();
    redirect_valid = 1'b1; redirect_pc = target;
    sample();
    drive_edge();
    redirect_valid = 1'b0;
    sample();
    vectors++;
    if (imem_rd !== 1'b1 || imem_addr !== target[7:1] || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_n1: rd=%b addr=%h valid=%b, expected 1 addr=%h 0",
               name, imem_rd, imem_addr, out_valid, target[7:1]);
    end
    drive_edge();
    sample();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_n2: out_valid=%b, expected 0", name, out_valid);
    end
    drive_edge();
    sample();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== first_pc || out_v0 !== ~target[0] || out_v1 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_n3: valid=%b pc=%h v0=%b v1=%b, expected 1 pc=%h v0=%b v1=1",
               name, out_valid, out_pc, out_v0, out_v1, first_pc, ~target[0]);
    end
    drive_edge();
    sample();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== second_pc || out_v0 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_n4: valid=%b pc=%h v0=%b, expected 1 pc=%h v0=1",
               name, out_valid, out_pc, out_v0, second_pc);
    end
  endtask

  task automatic test_halt_redirect();
    dec_ready = 1'b1;
    drive_edge();
    halt = 1'b1;
    sample();
    drive_edge();
    halt = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) drive_edge();
      sample();
      vectors++;
      if (imem_rd !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_rd_%0d: imem_rd=%b, expected 0", c, imem_rd);
      end
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_drained: out_valid=%b, expected 0", out_valid);
    end
    // Redirect out of HALTED with halt asserted in the same cycle: redirect wins.
    drive_edge();
    redirect_valid = 1'b1; redirect_pc = 8'h20; halt = 1'b1;
    sample();
    drive_edge();
    redirect_valid = 1'b0; halt = 1'b0;
    sample();
    vectors++;
    if (imem_rd !== 1'b1 || imem_addr !== 7'h10) begin
      miscompares++;
      $display("FAIL halt_resume_rd: rd=%b addr=%h, expected 1 addr=10", imem_rd, imem_addr);
    end
    repeat (2) begin
      drive_edge();
      sample();
    end
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 8'h20) begin
      miscompares++;
      $display("FAIL halt_resume_out: valid=%b pc=%h, expected 1 pc=20", out_valid, out_pc);
    end
    repeat (2) begin
      drive_edge();
      sample();
    end
    vectors++;
    if (imem_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_ignored: imem_rd=%b, expected 1", imem_rd);
    end
  endtask

  task automatic test_reset_mid();
    drive_edge();
    reset = 1'b0;
    drive_edge();
    reset = 1'b1; dec_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) drive_edge();
      sample();
    end
    vectors++;
    if (imem_rd !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_full: rd=%b valid=%b, expected 0/1", imem_rd, out_valid);
    end
    drive_edge();
    reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || imem_rd !== 1'b0 || out_pc !== 8'h00 || out_v1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_assert: valid=%b rd=%b pc=%h v1=%b, expected 0/0/00/0",
               out_valid, imem_rd, out_pc, out_v1);
    end
    drive_edge();
    reset = 1'b1; dec_ready = 1'b1;
    sample();
    vectors++;
    if (imem_rd !== 1'b1 || imem_addr !== 7'h00) begin
      miscompares++;
      $display("FAIL rmid_cycle0: rd=%b addr=%h, expected 1/00", imem_rd, imem_addr);
    end
    drive_edge();
    sample();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_cycle1: out_valid=%b, expected 0", out_valid);
    end
    drive_edge();
    sample();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00) begin
      miscompares++;
      $display("FAIL rmid_cycle2: valid=%b pc=%h, expected 1 pc=00", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      drive_edge();
      r              = int'($urandom_range(0, 99));
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = (r < 6);
      redirect_pc    = 8'($urandom);
      halt           = (r >= 6 && r < 9);
    end
    drive_edge();
    redirect_valid = 1'b0; halt = 1'b0; dec_ready = 1'b1;
    repeat (8) drive_edge();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {$urandom, $urandom};
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; halt = 1'b0; dec_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect(8'h15, "odd_redirect");
    test_redirect(8'hFE, "wrap");
    test_halt_redirect();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
